// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, branch squash and halt-drain FSM.
// Optional build macro IDEX_LOAD_USE_STALL_EN enables the load-use hazard detector.
module id_ex_stage #(
    parameter int DATA_W       = 32,
    parameter int PC_W         = 9,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_ALUSrc,
    input  logic [1:0]        id_MemtoReg,
    input  logic              id_RegWrite,
    input  logic              id_MemRead,
    input  logic              id_MemWrite,
    input  logic [2:0]        id_ALUOp,
    input  logic              id_Branch,
    input  logic              id_Jal_Sel,
    input  logic              id_Jalr_Sel,
    input  logic              id_Halt,
    input  logic [PC_W-1:0]   id_pc,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [2:0]        id_funct3,
    input  logic [6:0]        id_funct7,
    input  logic              ex_flush,
    output logic              ex_ALUSrc,
    output logic [1:0]        ex_MemtoReg,
    output logic              ex_RegWrite,
    output logic              ex_MemRead,
    output logic              ex_MemWrite,
    output logic [2:0]        ex_ALUOp,
    output logic              ex_Branch,
    output logic              ex_Jal_Sel,
    output logic              ex_Jalr_Sel,
    output logic              ex_Halt,
    output logic [PC_W-1:0]   ex_pc,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [2:0]        ex_funct3,
    output logic [6:0]        ex_funct7,
    output logic              stall,
    output logic              halted,
    output logic [1:0]        halt_state_o
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } halt_state_e;

    localparam int CTRL_W = 13;
    localparam int DW     = PC_W + 3 * DATA_W + 25;
    localparam int CNT_W  = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((DRAIN_CYCLES > 1) ? DRAIN_CYCLES - 1 : 0);

    halt_state_e       state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              halted_q;

    logic [CTRL_W-1:0] ctrl_d, ctrl_q;
    logic [DW-1:0]     data_d, data_q;
    logic              hazard;
    logic              freeze;
    logic              load_full;

    // Fetch freezes as soon as a halt sits in EX, one cycle before the FSM leaves RUN.
    assign freeze = ctrl_q[0] || (state_q != RUN);

`ifdef IDEX_LOAD_USE_STALL_EN
    logic rs1_used, rs2_used;
    assign rs1_used = !id_Jal_Sel;
    assign rs2_used = !id_ALUSrc || id_MemWrite;
    assign hazard   = ctrl_q[8] && (ex_rd != 5'd0) &&
                      ((rs1_used && (ex_rd == id_rs1)) || (rs2_used && (ex_rd == id_rs2)));
`else
    assign hazard = 1'b0;
`endif

    assign stall     = !ex_flush && (hazard || freeze);
    assign load_full = !ex_flush && !hazard && !freeze;

    assign ctrl_d = load_full ? {id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite,
                                 id_ALUOp, id_Branch, id_Jal_Sel, id_Jalr_Sel, id_Halt}
                              : '0;
    assign data_d = {id_pc, id_rd1, id_rd2, id_imm, id_rs1, id_rs2, id_rd, id_funct3, id_funct7};

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q <= '0;
            data_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            data_q <= data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (ctrl_q[0]) begin
                        if (DRAIN_CYCLES <= 1) begin
                            state_q  <= HALTED;
                            halted_q <= 1'b1;
                        end else begin
                            state_q <= DRAIN;
                            cnt_q   <= CNT_LOAD;
                        end
                    end
                end
                DRAIN: begin
                    if (cnt_q <= CNT_ONE) begin
                        state_q  <= HALTED;
                        cnt_q    <= '0;
                        halted_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                HALTED: begin
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q  <= RUN;
                    cnt_q    <= '0;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign {ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite,
            ex_ALUOp, ex_Branch, ex_Jal_Sel, ex_Jalr_Sel, ex_Halt} = ctrl_q;
    assign {ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7} = data_q;

    assign halted       = halted_q;
    assign halt_state_o = state_q;

endmodule
